// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types for the UART word-write arbiter: FSM states, word width and the
// round-robin winner helper used by uart_rr_pick.
package uart_tx_arbiter_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned MAX_REQ = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DRAIN
  } state_e;

  // First set bit at or after ptr, scanning upward with wrap modulo nreq.
  // Offsets are walked from high to low so the last hit is the nearest one.
  function automatic logic [2:0] rr_winner(input logic [MAX_REQ-1:0] req,
                                           input logic [2:0]         ptr,
                                           input logic [3:0]         nreq);
    logic [3:0] idx;
    logic [3:0] off;
    logic [2:0] win;
    win = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      off = 4'(MAX_REQ - 1 - k);
      idx = {1'b0, ptr} + off;
      if (idx >= nreq) idx = idx - nreq;
      if ((off < nreq) && req[idx[2:0]]) win = idx[2:0];
    end
    return win;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational winner select for the arbiter: winner index, one-hot grant
// vector and a valid flag; holds no state.
module uart_rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NREQ  = 3,
  parameter int unsigned PTR_W = 2
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic             valid_o,
  output logic [PTR_W-1:0] win_o,
  output logic [NREQ-1:0]  onehot_o
);

  logic [MAX_REQ-1:0] req_ext;
  logic [2:0]         win_w;

  always_comb begin
    req_ext             = '0;
    req_ext[NREQ-1:0]   = req_i;
    win_w               = rr_winner(req_ext, 3'(ptr_i), 4'(NREQ));
    win_o               = PTR_W'(win_w);
    onehot_o            = NREQ'(1) << win_o;
    valid_o             = |req_i;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares the UART transmitter's send/wrdata/busy port between NREQ requesters.
// Define UART_ARB_FIXED_PRIO_EN for lowest-index-wins instead of round-robin.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NREQ     = 3,
  parameter int unsigned START_TO = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [WORD_W*NREQ-1:0] req_data,
  output logic [NREQ-1:0]        gnt,
  input  logic                   pause,
  output logic                   send,
  output logic [WORD_W-1:0]      wrdata,
  input  logic                   busy,
  output logic                   idle,
  output logic                   to_err
);

  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CNT_W = $clog2(START_TO + 1);

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [NREQ-1:0]       gnt_q;
  logic                  send_q;
  logic [WORD_W-1:0]     wrdata_q;
  logic                  idle_q;
  logic                  to_err_q;

  logic                  pick_valid;
  logic [PTR_W-1:0]      pick_win;
  logic [NREQ-1:0]       pick_onehot;
  logic [WORD_W-1:0]     words [NREQ];

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      words[i] = req_data[i*WORD_W +: WORD_W];
    end
  end

`ifdef UART_ARB_FIXED_PRIO_EN
  uart_rr_pick #(.NREQ(NREQ), .PTR_W(PTR_W)) u_pick (
    .req_i    (req),
    .ptr_i    ('0),
    .valid_o  (pick_valid),
    .win_o    (pick_win),
    .onehot_o (pick_onehot)
  );
`else
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  assign ptr_d = (pick_win == PTR_W'(NREQ - 1)) ? '0 : pick_win + PTR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (state_q == IDLE && !pause && !busy && pick_valid) begin
      ptr_q <= ptr_d;
    end
  end

  uart_rr_pick #(.NREQ(NREQ), .PTR_W(PTR_W)) u_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .valid_o  (pick_valid),
    .win_o    (pick_win),
    .onehot_o (pick_onehot)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      gnt_q    <= '0;
      send_q   <= 1'b0;
      wrdata_q <= '0;
      idle_q   <= 1'b1;
      to_err_q <= 1'b0;
    end else begin
      gnt_q  <= '0;
      send_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!pause && !busy && pick_valid) begin
            send_q   <= 1'b1;
            gnt_q    <= pick_onehot;
            wrdata_q <= words[pick_win];
            cnt_q    <= '0;
            idle_q   <= 1'b0;
            state_q  <= START;
          end
        end
        START: begin
          // cnt_q counts cycles spent in START since the send cycle
          if (busy) begin
            state_q <= DRAIN;
          end else if (cnt_q == CNT_W'(START_TO)) begin
            to_err_q <= 1'b1;
            idle_q   <= 1'b1;
            state_q  <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DRAIN: begin
          if (!busy) begin
            idle_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          idle_q  <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt    = gnt_q;
  assign send   = send_q;
  assign wrdata = wrdata_q;
  assign idle   = idle_q;
  assign to_err = to_err_q;

endmodule
